sc_jug_shiftctrl: RTL and testbench
===================================

Name: sc_jug_shiftctrl

Overview:
- Command generator for the player position register.
- Converts two raw active-low push-buttons (left, right) into single-cycle 2-bit shift-select commands.
- Provides synchronisation, debounce, hold-to-repeat and playfield-edge blocking, using the registered player position fed back from the register.
- Sits between the board button pins and the player register's shift-select input; 2'b01 = shift toward MSB (left), 2'b10 = shift toward LSB (right), 2'b00 = hold.

Parameters:
- JUGCTRL_DATAWIDTH, 8, width of player position bus.
- JUGCTRL_DEBOUNCE_CYCLES, 500000, consecutive stable cycles required to accept a press (10 ms at 50 MHz); must be >=2.
- JUGCTRL_REPEAT_DELAY, 25000000, cycles from first accepted shift to first auto-repeat shift (0.5 s).
- JUGCTRL_REPEAT_PERIOD, 7500000, cycles between subsequent auto-repeat shifts (0.15 s).
- JUGCTRL_CNTWIDTH, 25, width of internal counters; must hold the largest of the three cycle parameters.

Ports:
- SC_REGJUG_CLOCK_50  input  1  system clock, 50 MHz.
- SC_REGJUG_RESET_InHigh  input  1  reset, asynchronous, active-high.
- SC_JUGCTRL_left_InLow  input  1  raw left button, active low, asynchronous to clock.
- SC_JUGCTRL_right_InLow  input  1  raw right button, active low, asynchronous to clock.
- SC_JUGCTRL_enable_InHigh  input  1  game-running qualifier; 0 forces IDLE.
- SC_JUGCTRL_position_InBUS  input  JUGCTRL_DATAWIDTH  current player register contents.
- SC_JUGCTRL_shiftselection_OutBUS  output  2  registered shift command to the player register.
- SC_JUGCTRL_busy_OutHigh  output  1  high whenever FSM is not IDLE.

Behaviour:
- Clock is SC_REGJUG_CLOCK_50. Reset is SC_REGJUG_RESET_InHigh, asynchronous, active-high.
- Reset values: shiftselection=2'b00, busy=0, FSM=IDLE, all counters 0, synchroniser flops=1 (released).
- Each button passes through a 2-flop synchroniser. The request vector req = {left_sync==0, right_sync==0}.
- req 2'b11 (both pressed) and 2'b00 are both treated as "no request".
- States and transitions:
  - IDLE: counter cleared. A valid single-button req latches the direction into dir, goes to DEBOUNCE, counter=1.
  - DEBOUNCE: counter increments while req==dir. If req!=dir, return to IDLE. When counter reaches JUGCTRL_DEBOUNCE_CYCLES, go to FIRE.
  - FIRE: one cycle only. Outputs the command (subject to edge blocking), then goes to DELAY with counter=0.
  - DELAY: counter increments while req==dir. At JUGCTRL_REPEAT_DELAY-1, go to FIRE_R.
  - FIRE_R: one cycle only. Outputs the command, then goes to REPEAT with counter=0.
  - REPEAT: counter increments while req==dir. At JUGCTRL_REPEAT_PERIOD-1, go to FIRE_R.
  - In DELAY or REPEAT, req!=dir returns to IDLE (release, direction change or both pressed). A new direction then needs a full debounce.
- Output timing:
  - shiftselection is registered. It equals the command in the cycle after the FSM occupies FIRE/FIRE_R, and is 2'b00 in every other cycle: exactly one cycle wide.
  - First pulse appears 2 + JUGCTRL_DEBOUNCE_CYCLES + 1 rising edges after the first edge that samples the pressed pin.
  - Repeat pulses are spaced JUGCTRL_REPEAT_DELAY + 1, then JUGCTRL_REPEAT_PERIOD + 1, cycles apart.
- Edge blocking, evaluated from position in the FIRE/FIRE_R cycle:
  - Left is suppressed (output 2'b00) if position[MSB]==1.
  - Right is suppressed if position[0]==1.
  - A suppressed FIRE still advances the FSM normally.
  - position==0 (register cleared) is never blocked.
- enable==0 forces IDLE and 2'b00 on the next edge from any state; counters clear.
- Reset mid-operation: immediate return to reset values; no pulse is emitted on reset release.
- busy=1 in every state except IDLE, registered alongside shiftselection.

Optional Feature:
- Macro: SC_JUGCTRL_WRAP_EN.
- When defined, edge blocking is removed: FIRE/FIRE_R always emit the command, and the player register's rotate wraps the player around the playfield.
- When undefined (default), edge blocking is active as above.
- The position input stays in the port list in both builds; it is simply unused when the macro is defined.

Decomposition:
- Shared package sc_jug_pkg:
  - shift command encodings SHIFT_HOLD=2'b00, SHIFT_LEFT=2'b01, SHIFT_RIGHT=2'b10 (shared with the player register);
  - FSM state encoding (IDLE, DEBOUNCE, FIRE, DELAY, FIRE_R, REPEAT).
- One natural sub-module: sc_jug_btnsync, the 2-flop synchroniser for both buttons, instantiated once with width 2.

Test Plan (bench params: DEBOUNCE=4, REPEAT_DELAY=10, REPEAT_PERIOD=5, DATAWIDTH=8):
- Reset mid-press: assert reset while in DELAY -> output 2'b00 and busy=0 immediately; after release, no pulse until a fresh press completes debounce.
- Single press: position=8'b01000100, left held 3 cycles then released, never reaching debounce -> shiftselection stays 2'b00, FSM back to IDLE. Left held 30 cycles -> one 2'b01 pulse at edge 7 after the press, repeats at +11 and +17, +23.
- Bounce: right toggled every 2 cycles for 20 cycles, then held -> no pulse during toggling; exactly one 2'b10 pulse 7 cycles after the final stable low.
- Edge block: position=8'b10000000, left held 20 cycles -> no 2'b01 pulse ever, busy=1 throughout. With SC_JUGCTRL_WRAP_EN defined -> 2'b01 pulses occur.
- Both buttons: right held into REPEAT, then left also pressed -> FSM to IDLE, output 2'b00 from then on, no pulses while both are held.
- Enable drop: enable 1->0 in REPEAT -> next edge IDLE, busy=0, no further pulses while the button stays held.

Source files
------------

// File: rtl/sc_jug_pkg.sv
// Shared encodings for the player register and its shift controller:
// shift-select commands, button request patterns and FSM state codes.
package sc_jug_pkg;

  localparam logic [1:0] SHIFT_HOLD  = 2'b00;
  localparam logic [1:0] SHIFT_LEFT  = 2'b01;
  localparam logic [1:0] SHIFT_RIGHT = 2'b10;

  // req = {left pressed, right pressed}
  localparam logic [1:0] REQ_LEFT  = 2'b10;
  localparam logic [1:0] REQ_RIGHT = 2'b01;

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] DEBOUNCE = 3'd1;
  localparam logic [2:0] FIRE     = 3'd2;
  localparam logic [2:0] DELAY    = 3'd3;
  localparam logic [2:0] FIRE_R   = 3'd4;
  localparam logic [2:0] REPEAT   = 3'd5;

  function automatic logic [1:0] req_to_cmd(
    input logic [1:0] r
  );
    return (r == REQ_LEFT) ? SHIFT_LEFT : SHIFT_RIGHT;
  endfunction

endpackage

// File: rtl/sc_jug_shiftctrl_if.sv
// Button/position inputs and shift-command outputs of the controller.
// slave: controller side; master: board/player-register side.
interface sc_jug_shiftctrl_if #(
  parameter int DW = 8
);
  logic          SC_JUGCTRL_left_InLow;
  logic          SC_JUGCTRL_right_InLow;
  logic          SC_JUGCTRL_enable_InHigh;
  logic [DW-1:0] SC_JUGCTRL_position_InBUS;
  logic [1:0]    SC_JUGCTRL_shiftselection_OutBUS;
  logic          SC_JUGCTRL_busy_OutHigh;

  modport slave (
    input  SC_JUGCTRL_left_InLow,
    input  SC_JUGCTRL_right_InLow,
    input  SC_JUGCTRL_enable_InHigh,
    input  SC_JUGCTRL_position_InBUS,
    output SC_JUGCTRL_shiftselection_OutBUS,
    output SC_JUGCTRL_busy_OutHigh
  );

  modport master (
    output SC_JUGCTRL_left_InLow,
    output SC_JUGCTRL_right_InLow,
    output SC_JUGCTRL_enable_InHigh,
    output SC_JUGCTRL_position_InBUS,
    input  SC_JUGCTRL_shiftselection_OutBUS,
    input  SC_JUGCTRL_busy_OutHigh
  );
endinterface

// File: rtl/sc_jug_btnsync.sv
// Two-flop synchroniser for W raw button pins; flops reset to 1
// (released) so no press is seen while coming out of reset.
module sc_jug_btnsync #(
  parameter int W = 2
) (
  input  logic         SC_REGJUG_CLOCK_50,
  input  logic         SC_REGJUG_RESET_InHigh,
  input  logic [W-1:0] btn_raw,
  output logic [W-1:0] btn_sync
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge SC_REGJUG_CLOCK_50 or
              posedge SC_REGJUG_RESET_InHigh) begin
    if (SC_REGJUG_RESET_InHigh) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= btn_raw;
      sync_q <= meta_q;
    end
  end

  assign btn_sync = sync_q;

endmodule

// File: rtl/sc_jug_shiftctrl.sv
// Turns left/right push-buttons into one-cycle shift commands with
// debounce, hold-to-repeat and playfield-edge blocking.
// Ports: clock, async active-high reset, bus (sc_jug_shiftctrl_if.slave).
// Build option SC_JUGCTRL_WRAP_EN: drop edge blocking (rotate wraps).
module sc_jug_shiftctrl
  import sc_jug_pkg::*;
#(
  parameter int JUGCTRL_DATAWIDTH       = 8,
  parameter int JUGCTRL_DEBOUNCE_CYCLES = 500000,
  parameter int JUGCTRL_REPEAT_DELAY    = 25000000,
  parameter int JUGCTRL_REPEAT_PERIOD   = 7500000,
  parameter int JUGCTRL_CNTWIDTH        = 25
) (
  input logic SC_REGJUG_CLOCK_50,
  input logic SC_REGJUG_RESET_InHigh,
  sc_jug_shiftctrl_if.slave bus
);

  localparam int CW = JUGCTRL_CNTWIDTH;
  localparam int MSB = JUGCTRL_DATAWIDTH - 1;

  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] DB_END  =
    CW'(JUGCTRL_DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] RD_END  =
    CW'(JUGCTRL_REPEAT_DELAY - 1);
  localparam logic [CW-1:0] RP_END  =
    CW'(JUGCTRL_REPEAT_PERIOD - 1);

  logic [1:0]    btn_sync;
  logic [1:0]    req;
  logic          req_one;
  logic [2:0]    st_q, st_d;
  logic [1:0]    dir_q, dir_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    sel_q, sel_d;
  logic [1:0]    dir_cmd;
  logic [1:0]    fire_cmd;

  sc_jug_btnsync #(
    .W (2)
  ) u_sync (
    .SC_REGJUG_CLOCK_50     (SC_REGJUG_CLOCK_50),
    .SC_REGJUG_RESET_InHigh (SC_REGJUG_RESET_InHigh),
    .btn_raw  ({bus.SC_JUGCTRL_left_InLow,
                bus.SC_JUGCTRL_right_InLow}),
    .btn_sync (btn_sync)
  );

  assign req     = ~btn_sync;
  // Exactly one button: both-pressed counts as no request.
  assign req_one = ^req;
  assign dir_cmd = req_to_cmd(dir_q);

`ifdef SC_JUGCTRL_WRAP_EN
  assign fire_cmd = dir_cmd;
`else
  logic blk;
  // An empty register (all zero) has neither edge bit set.
  assign blk =
    ((dir_cmd == SHIFT_LEFT) &&
     bus.SC_JUGCTRL_position_InBUS[MSB]) ||
    ((dir_cmd == SHIFT_RIGHT) &&
     bus.SC_JUGCTRL_position_InBUS[0]);
  assign fire_cmd = blk ? SHIFT_HOLD : dir_cmd;
`endif

  always_comb begin
    st_d  = st_q;
    dir_d = dir_q;
    cnt_d = cnt_q;
    sel_d = SHIFT_HOLD;
    if (!bus.SC_JUGCTRL_enable_InHigh) begin
      st_d  = IDLE;
      cnt_d = '0;
    end else begin
      unique case (st_q)
        IDLE: begin
          cnt_d = '0;
          if (req_one) begin
            dir_d = req;
            st_d  = DEBOUNCE;
            cnt_d = CNT_ONE;
          end
        end
        DEBOUNCE: begin
          if (req != dir_q) begin
            st_d  = IDLE;
            cnt_d = '0;
          end else if (cnt_q == DB_END) begin
            st_d = FIRE;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        FIRE: begin
          sel_d = fire_cmd;
          st_d  = DELAY;
          cnt_d = '0;
        end
        DELAY: begin
          if (req != dir_q) begin
            st_d  = IDLE;
            cnt_d = '0;
          end else if (cnt_q == RD_END) begin
            st_d = FIRE_R;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        FIRE_R: begin
          sel_d = fire_cmd;
          st_d  = REPEAT;
          cnt_d = '0;
        end
        REPEAT: begin
          if (req != dir_q) begin
            st_d  = IDLE;
            cnt_d = '0;
          end else if (cnt_q == RP_END) begin
            st_d = FIRE_R;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: begin
          st_d  = IDLE;
          cnt_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge SC_REGJUG_CLOCK_50 or
              posedge SC_REGJUG_RESET_InHigh) begin
    if (SC_REGJUG_RESET_InHigh) begin
      st_q  <= IDLE;
      dir_q <= '0;
      cnt_q <= '0;
      sel_q <= SHIFT_HOLD;
    end else begin
      st_q  <= st_d;
      dir_q <= dir_d;
      cnt_q <= cnt_d;
      sel_q <= sel_d;
    end
  end

  assign bus.SC_JUGCTRL_shiftselection_OutBUS = sel_q;
  assign bus.SC_JUGCTRL_busy_OutHigh = (st_q != IDLE);

endmodule

// File: tb/tb_sc_jug_shiftctrl.sv
// Directed bench for sc_jug_shiftctrl with short timing parameters:
// debounce 4, repeat delay 10, repeat period 5, 8-bit position.
module tb_sc_jug_shiftctrl;

  logic clk;
  logic rst;

  int npass;
  int ntot;
  int cyc;
  int t0;
  int prel[$];
  logic [1:0] pval[$];
  int busy_lo_late;
  int busy_hi;

  sc_jug_shiftctrl_if #(.DW(8)) bus ();

  sc_jug_shiftctrl #(
    .JUGCTRL_DATAWIDTH       (8),
    .JUGCTRL_DEBOUNCE_CYCLES (4),
    .JUGCTRL_REPEAT_DELAY    (10),
    .JUGCTRL_REPEAT_PERIOD   (5),
    .JUGCTRL_CNTWIDTH        (25)
  ) dut (
    .SC_REGJUG_CLOCK_50     (clk),
    .SC_REGJUG_RESET_InHigh (rst),
    .bus                    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: got %0d expected %0d",
                tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic clr();
    prel.delete();
    pval.delete();
    busy_lo_late = 0;
    busy_hi = 0;
    t0 = cyc;
  endtask

  task automatic watch(input int n);
    int rel;
    for (int i = 0; i < n; i++) begin
      tick();
      rel = cyc - t0 - 1;
      if (bus.SC_JUGCTRL_shiftselection_OutBUS !== 2'b00) begin
        prel.push_back(rel);
        pval.push_back(bus.SC_JUGCTRL_shiftselection_OutBUS);
      end
      if (bus.SC_JUGCTRL_busy_OutHigh !== 1'b0) busy_hi++;
      if (rel >= 2 && bus.SC_JUGCTRL_busy_OutHigh !== 1'b1)
        busy_lo_late++;
    end
  endtask

  function automatic int pat(input int k);
    return (k < prel.size()) ? prel[k] : -1;
  endfunction

  function automatic logic [1:0] pv(input int k);
    return (k < pval.size()) ? pval[k] : 2'bxx;
  endfunction

  initial begin
    npass = 0;
    ntot = 0;
    cyc = 0;
    rst = 1'b1;
    bus.SC_JUGCTRL_left_InLow = 1'b1;
    bus.SC_JUGCTRL_right_InLow = 1'b1;
    bus.SC_JUGCTRL_enable_InHigh = 1'b1;
    bus.SC_JUGCTRL_position_InBUS = 8'h00;
    tick();
    tick();
    chk("rst_sel", bus.SC_JUGCTRL_shiftselection_OutBUS, 0);
    chk("rst_busy", bus.SC_JUGCTRL_busy_OutHigh, 0);
    rst = 1'b0;
    tick();
    tick();

    // Short press: released before debounce completes
    bus.SC_JUGCTRL_position_InBUS = 8'b01000100;
    bus.SC_JUGCTRL_left_InLow = 1'b0;
    clr();
    watch(3);
    bus.SC_JUGCTRL_left_InLow = 1'b1;
    watch(12);
    chk("short_npulse", prel.size(), 0);
    chk("short_idle", bus.SC_JUGCTRL_busy_OutHigh, 0);

    // Long left hold: first pulse and three repeats
    bus.SC_JUGCTRL_left_InLow = 1'b0;
    clr();
    watch(31);
    chk("hold_npulse", prel.size(), 4);
    chk("hold_p0_t", pat(0), 7);
    chk("hold_p1_t", pat(1), 18);
    chk("hold_p2_t", pat(2), 24);
    chk("hold_p3_t", pat(3), 30);
    chk("hold_p0_v", pv(0), 2'b01);
    chk("hold_p3_v", pv(3), 2'b01);
    chk("hold_busy", busy_lo_late, 0);
    bus.SC_JUGCTRL_left_InLow = 1'b1;
    clr();
    watch(10);
    chk("rel_npulse", prel.size(), 0);
    chk("rel_idle", bus.SC_JUGCTRL_busy_OutHigh, 0);

    // Bouncing right button, then stable low
    clr();
    for (int i = 0; i < 10; i++) begin
      bus.SC_JUGCTRL_right_InLow = i[0];
      watch(2);
    end
    chk("bounce_npulse", prel.size(), 0);
    bus.SC_JUGCTRL_right_InLow = 1'b0;
    clr();
    watch(12);
    chk("bounce_after_n", prel.size(), 1);
    chk("bounce_after_t", pat(0), 7);
    chk("bounce_after_v", pv(0), 2'b10);
    bus.SC_JUGCTRL_right_InLow = 1'b1;
    watch(5);

    // Left edge: player already at MSB
    bus.SC_JUGCTRL_position_InBUS = 8'b10000000;
    bus.SC_JUGCTRL_left_InLow = 1'b0;
    clr();
    watch(20);
`ifdef SC_JUGCTRL_WRAP_EN
    chk("lblk_npulse", prel.size(), 2);
    chk("lblk_p0_v", pv(0), 2'b01);
`else
    chk("lblk_npulse", prel.size(), 0);
`endif
    chk("lblk_busy", busy_lo_late, 0);
    bus.SC_JUGCTRL_left_InLow = 1'b1;
    watch(5);

    // Right edge: player already at LSB
    bus.SC_JUGCTRL_position_InBUS = 8'b00000001;
    bus.SC_JUGCTRL_right_InLow = 1'b0;
    clr();
    watch(10);
`ifdef SC_JUGCTRL_WRAP_EN
    chk("rblk_npulse", prel.size(), 1);
`else
    chk("rblk_npulse", prel.size(), 0);
`endif
    chk("rblk_busy", busy_lo_late, 0);
    bus.SC_JUGCTRL_right_InLow = 1'b1;
    watch(5);

    // Both buttons: right into REPEAT, then left too
    bus.SC_JUGCTRL_position_InBUS = 8'b00010000;
    bus.SC_JUGCTRL_right_InLow = 1'b0;
    clr();
    watch(20);
    chk("both_pre_n", prel.size(), 2);
    chk("both_pre_t1", pat(1), 18);
    bus.SC_JUGCTRL_left_InLow = 1'b0;
    clr();
    watch(15);
    chk("both_npulse", prel.size(), 0);
    chk("both_idle", bus.SC_JUGCTRL_busy_OutHigh, 0);
    bus.SC_JUGCTRL_left_InLow = 1'b1;
    bus.SC_JUGCTRL_right_InLow = 1'b1;
    watch(5);

    // Enable drop while in REPEAT
    bus.SC_JUGCTRL_right_InLow = 1'b0;
    clr();
    watch(20);
    chk("en_pre_n", prel.size(), 2);
    bus.SC_JUGCTRL_enable_InHigh = 1'b0;
    tick();
    chk("en_busy", bus.SC_JUGCTRL_busy_OutHigh, 0);
    chk("en_sel", bus.SC_JUGCTRL_shiftselection_OutBUS, 0);
    clr();
    watch(20);
    chk("en_npulse", prel.size(), 0);
    chk("en_busy_hold", busy_hi, 0);
    bus.SC_JUGCTRL_right_InLow = 1'b1;
    watch(3);
    bus.SC_JUGCTRL_enable_InHigh = 1'b1;
    watch(3);

    // Reset while in DELAY, button kept held
    bus.SC_JUGCTRL_position_InBUS = 8'h00;
    bus.SC_JUGCTRL_right_InLow = 1'b0;
    clr();
    watch(10);
    chk("rmid_pre_n", prel.size(), 1);
    chk("rmid_pre_t", pat(0), 7);
    rst = 1'b1;
    #1;
    chk("rmid_busy", bus.SC_JUGCTRL_busy_OutHigh, 0);
    chk("rmid_sel", bus.SC_JUGCTRL_shiftselection_OutBUS, 0);
    tick();
    tick();
    tick();
    rst = 1'b0;
    clr();
    watch(12);
    chk("rmid_post_n", prel.size(), 1);
    chk("rmid_post_t", pat(0), 7);
    chk("rmid_post_v", pv(0), 2'b10);
    bus.SC_JUGCTRL_right_InLow = 1'b1;
    watch(5);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
